fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation WISC core; replaces the single-cycle "PC addresses memory, instruction used same cycle" scheme.
- Issues PC-sequential requests to a variable-latency instruction memory and buffers returned words with their PCs in a DEPTH-entry FIFO.
- Presents buffered words to decode over a valid/ready handshake; handles branch redirect (flush) and stops fetching on HLT.

---
 rtl/fetch_queue_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end. Issues PC-sequential requests to a
//   variable-latency instruction memory, with at most one request
//   outstanding. Returned words are buffered with their PCs in a DEPTH-entry
//   first-word-fall-through FIFO. Decode consumes them over a valid/ready
//   handshake. A redirect flushes the FIFO and restarts fetch. Fetch stops
//   after an HLT word is returned. Once that HLT is consumed by decode, the
//   unit freezes until reset.
//
//   Optional build macro: FETCH_PERF_EN adds three saturating 32-bit
//   performance counters (perf_fetched, perf_starve, perf_flushed).
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   imem_req_*         fetch request (valid/addr out, ready in)
//   imem_resp_*        in-order response word from instruction memory
//   redirect_*         single-cycle flush pulse with the new fetch PC
//   out_*              FIFO head: valid, instruction, PC, PC + PC_STEP; ready in
//   halted             sticky; set once an HLT word has been consumed
//   buf_count          number of occupied FIFO entries
//   perf_*             (FETCH_PERF_EN only) performance counters
module fetch_queue_unit #(
  parameter int              ADDR_W      = 16,
  parameter int              INSTR_W     = 16,
  parameter int              DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int              PC_STEP     = 2,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_resp_valid,
  input  logic [INSTR_W-1:0]         imem_resp_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_next,
  input  logic                       out_ready,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] buf_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_starve,
  output logic [31:0]                perf_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_STOP} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_req_pc;
  logic                r_inflight;
  logic                r_discard;
  logic                r_halted;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [INSTR_W-1:0]  r_instr_q [DEPTH];
  logic [ADDR_W-1:0]   r_pc_q    [DEPTH];

  logic                w_redirect;
  logic                w_credit_ok;
  logic                w_req_fire;
  logic                w_resp;
  logic                w_resp_halt;
  logic                w_push;
  logic                w_pop;
  logic                w_head_halt;

  // A redirect is ignored once halted; everything else keys off w_redirect.
  assign w_redirect  = redirect_valid & ~r_halted;

  // Credit check counts the in-flight word so a response always has a slot.
  assign w_credit_ok = (int'(r_count) + int'(r_inflight)) < DEPTH;

  assign imem_req_valid = (r_state == S_REQ) & w_credit_ok & ~redirect_valid
                        & ~r_halted & ~rst;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_resp      = (r_state == S_WAIT) & imem_resp_valid;
  assign w_resp_halt = (imem_resp_data[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign w_push      = w_resp & ~r_discard & ~w_redirect;

  assign out_valid   = (r_count != '0) & ~redirect_valid;
  assign out_instr   = r_instr_q[r_rd_ptr];
  assign out_pc      = r_pc_q[r_rd_ptr];
  assign out_pc_next = out_pc + ADDR_W'(PC_STEP);
  assign w_pop       = out_valid & out_ready & ~r_halted;
  assign w_head_halt = (out_instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  assign halted      = r_halted;
  assign buf_count   = r_count;

  // Control: FSM, fetch PC, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_halted   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_pop && w_head_halt) begin
        r_halted <= 1'b1;
      end
      if (w_redirect) begin
        r_fetch_pc <= redirect_pc;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        // A response landing in the redirect cycle retires the outstanding
        // request (its word is dropped), so only a still-pending request
        // needs a discard marker.
        if (r_inflight && !imem_resp_valid) begin
          r_state   <= S_WAIT;
          r_discard <= 1'b1;
        end else begin
          r_state    <= S_REQ;
          r_inflight <= 1'b0;
          r_discard  <= 1'b0;
        end
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        case (r_state)
          S_REQ: begin
            if (w_req_fire) begin
              r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
              r_inflight <= 1'b1;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              r_inflight <= 1'b0;
              r_discard  <= 1'b0;
              // A discarded HLT must not stop fetch.
              if (!r_discard && w_resp_halt) begin
                r_state <= S_STOP;
              end else begin
                r_state <= S_REQ;
              end
            end
          end
          S_STOP: begin
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_REQ;
          end
        endcase
      end
    end
  end

  // Data: request PC capture and FIFO storage (no reset needed)
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_req_pc <= r_fetch_pc;
    end
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= imem_resp_data;
      r_pc_q[r_wr_ptr]    <= r_req_pc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_starve;
  logic [31:0] r_perf_flushed;
  logic        w_dropped;
  logic [31:0] w_flush_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // A response is dropped either by a pending discard or by a same-cycle redirect.
  assign w_dropped   = w_resp & (r_discard | w_redirect);
  assign w_flush_inc = (w_redirect ? 32'(r_count) : 32'd0) + 32'(w_dropped);

  // Performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_starve  <= '0;
      r_perf_flushed <= '0;
    end else begin
      r_perf_fetched <= sat_add(r_perf_fetched, 32'(w_push));
      r_perf_starve  <= sat_add(r_perf_starve, 32'(out_ready & ~out_valid & ~r_halted));
      r_perf_flushed <= sat_add(r_perf_flushed, w_flush_inc);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_starve  = r_perf_starve;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [15:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_next;
  logic        out_ready = 1'b0;
  logic        halted;
  logic [2:0]  buf_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_starve, perf_flushed;
`endif

  fetch_queue_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .out_ready(out_ready),
    .halted(halted), .buf_count(buf_count)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_starve(perf_starve), .perf_flushed(perf_flushed)
`endif
  );

  // DUT B: reset PC near the top of the address space
  logic        b_rst = 1'b1;
  logic        b_req_valid;
  logic [15:0] b_req_addr;
  logic        b_resp_valid = 1'b0;
  logic [15:0] b_resp_data = '0;
  logic        b_out_valid;
  logic [15:0] b_out_instr;
  logic [15:0] b_out_pc;
  logic [15:0] b_out_pc_next;
  logic        b_halted;
  logic [2:0]  b_buf_count;
`ifdef FETCH_PERF_EN
  logic [31:0] b_perf_fetched, b_perf_starve, b_perf_flushed;
`endif

  fetch_queue_unit #(.RESET_PC(16'hFFFE)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
    .imem_req_ready(1'b1),
    .imem_resp_valid(b_resp_valid), .imem_resp_data(b_resp_data),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .out_valid(b_out_valid), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_pc_next(b_out_pc_next), .out_ready(1'b1),
    .halted(b_halted), .buf_count(b_buf_count)
`ifdef FETCH_PERF_EN
    , .perf_fetched(b_perf_fetched), .perf_starve(b_perf_starve), .perf_flushed(b_perf_flushed)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Memory model / scoreboard state for DUT A
  int          lat = 1;
  bit          use_prog = 1'b0;
  logic [15:0] hlt_at = 16'hFFFF;
  int          mem_cnt = 0;
  logic [15:0] mem_pend = '0;
  int          acc_cnt = 0;
  logic [15:0] last_acc = '0;
  int          pop_cnt = 0;
  logic [15:0] last_pop_pc = '0;
  bit          halt_pop_seen = 1'b0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == hlt_at) return 16'hF000;
    if (use_prog) begin
      case (a)
        16'h0000: return 16'h1123;
        16'h0002: return 16'h2234;
        16'h0004: return 16'h3345;
        16'h0006: return 16'hF000;
        default:  ;
      endcase
    end
    return {4'h1, a[11:0]};
  endfunction

  // Memory responder and output scoreboard for DUT A (mid-cycle)
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mem_cnt = 0;
      imem_resp_valid = 1'b0;
    end else begin
      if (out_valid && out_ready && !halted) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got pc=%h instr=%h want no output", out_pc, out_instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_instr !== e.instr || out_pc !== e.pc || out_pc_next !== (e.pc + 16'd2)) begin
            errors++;
            $display("FAIL pop_data got instr=%h pc=%h next=%h want instr=%h pc=%h next=%h",
                     out_instr, out_pc, out_pc_next, e.instr, e.pc, e.pc + 16'd2);
          end
        end
        pop_cnt++;
        last_pop_pc = out_pc;
        if (out_instr[15:12] == 4'hF) halt_pop_seen = 1'b1;
      end
      if (redirect_valid && !halted) exp_q.delete();
      imem_resp_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_pend);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_pend = imem_req_addr;
        mem_cnt  = lat;
        acc_cnt++;
        last_acc = imem_req_addr;
        exp_q.push_back({mem_word(imem_req_addr), imem_req_addr});
      end
    end
  end

  // Memory responder and capture for DUT B (1-cycle latency)
  int          b_cnt = 0;
  logic [15:0] b_pend = '0;
  int          b_pop_n = 0;
  logic [15:0] b_pc [2];
  logic [15:0] b_nx [2];
  logic [15:0] b_in [2];

  always @(negedge clk) begin
    if (b_rst) begin
      b_cnt = 0;
      b_resp_valid = 1'b0;
    end else begin
      if (b_out_valid && b_pop_n < 2) begin
        b_pc[b_pop_n] = b_out_pc;
        b_nx[b_pop_n] = b_out_pc_next;
        b_in[b_pop_n] = b_out_instr;
        b_pop_n++;
      end
      b_resp_valid = 1'b0;
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          b_resp_valid = 1'b1;
          b_resp_data  = {4'h2, b_pend[11:0]};
        end
      end
      if (b_req_valid) begin
        b_pend = b_req_addr;
        b_cnt  = 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cyc(1);
    acc_cnt = 0;
    pop_cnt = 0;
    halt_pop_seen = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(2);
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (buf_count !== 3'd0) begin errors++; $display("FAIL reset_buf_count got %0d want 0", buf_count); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++;
    if (imem_req_addr !== 16'h0000) begin errors++; $display("FAIL reset_req_addr got %h want 0000", imem_req_addr); end
  endtask

  task automatic test_program_halt();
    bit ok = 1'b0;
    lat = 1; use_prog = 1'b1; out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (halt_pop_seen) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL prog_halt_pop got none want HLT pop within 60 cycles"); end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL prog_halted_next got %b want 1", halted); end
    cyc(10);
    checks++;
    if (acc_cnt != 4 || last_acc !== 16'h0006) begin
      errors++; $display("FAIL prog_requests got %0d last=%h want 4 last=0006", acc_cnt, last_acc);
    end
    checks++;
    if (pop_cnt != 4) begin errors++; $display("FAIL prog_pops got %0d want 4", pop_cnt); end
    checks++;
    if (halted !== 1'b1 || imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL prog_frozen got halted=%b req=%b ov=%b want 1 0 0", halted, imem_req_valid, out_valid);
    end
    use_prog = 1'b0;
  endtask

  task automatic test_credit();
    lat = 1; out_ready = 1'b0;
    do_reset();
    cyc(15);
    checks++;
    if (acc_cnt != 4 || last_acc !== 16'h0006) begin
      errors++; $display("FAIL credit_requests got %0d last=%h want 4 last=0006", acc_cnt, last_acc);
    end
    checks++;
    if (buf_count !== 3'd4 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL credit_full got count=%0d req=%b want 4 0", buf_count, imem_req_valid);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(10);
    checks++;
    if (acc_cnt != 5 || last_acc !== 16'h0008) begin
      errors++; $display("FAIL credit_refill got %0d last=%h want 5 last=0008", acc_cnt, last_acc);
    end
    checks++;
    if (buf_count !== 3'd4 || pop_cnt != 1) begin
      errors++; $display("FAIL credit_refill_count got count=%0d pops=%0d want 4 1", buf_count, pop_cnt);
    end
  endtask

  task automatic test_redirect_flush();
    bit ok = 1'b0;
    int p0;
    lat = 3; out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (buf_count == 3'd3 && mem_cnt >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL redir_setup got count=%0d want 3 with request in flight", buf_count); end
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    cyc(1);
    redirect_valid = 1'b0;
    checks++;
    if (buf_count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_flush got count=%0d ov=%b want 0 0", buf_count, out_valid);
    end
    p0 = pop_cnt;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (pop_cnt > p0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || last_pop_pc !== 16'h0100) begin
      errors++; $display("FAIL redir_first_pc got %h want 0100", last_pop_pc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_flushed !== 32'd4) begin errors++; $display("FAIL redir_perf_flushed got %0d want 4", perf_flushed); end
`endif
  endtask

  task automatic test_redirect_on_hlt();
    bit ok = 1'b0;
    int p0;
    lat = 2; out_ready = 1'b1; hlt_at = 16'h0004;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (mem_cnt == 1 && mem_pend == 16'h0004) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL hltredir_setup got none want HLT response pending"); end
    p0 = pop_cnt;
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    cyc(1);
    redirect_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (pop_cnt > p0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || last_pop_pc !== 16'h0200) begin
      errors++; $display("FAIL hltredir_resume got %h want 0200", last_pop_pc);
    end
    cyc(8);
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL hltredir_halted got %b want 0", halted); end
    hlt_at = 16'hFFFF;
  endtask

  task automatic test_reset_mid_wait();
    bit ok = 1'b0;
    lat = 3; out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (buf_count == 3'd2 && mem_cnt >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_setup got count=%0d want 2 with request in flight", buf_count); end
    rst = 1'b1;
    cyc(1);
    checks++;
    if (out_valid !== 1'b0 || buf_count !== 3'd0 || imem_req_addr !== 16'h0000 || halted !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got ov=%b count=%0d addr=%h halted=%b want 0 0 0000 0",
                         out_valid, buf_count, imem_req_addr, halted);
    end
    pop_cnt = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (pop_cnt > 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || last_pop_pc !== 16'h0000) begin
      errors++; $display("FAIL rstmid_first_pc got %h want 0000", last_pop_pc);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    bit ok = 1'b0;
    logic [15:0] held;
    lat = 1; out_ready = 1'b1;
    do_reset();
    cyc(4);
    a0 = acc_cnt;
    cyc(20);
    checks++;
    if (acc_cnt - a0 != 10) begin errors++; $display("FAIL b2b_rate got %0d want 10 requests in 20 cycles", acc_cnt - a0); end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (imem_req_valid) begin ok = 1'b1; break; end
    end
    held = imem_req_addr;
    a0 = acc_cnt;
    cyc(3);
    checks++;
    if (!ok || imem_req_valid !== 1'b1 || imem_req_addr !== held || acc_cnt != a0) begin
      errors++; $display("FAIL b2b_stall got req=%b addr=%h acc=%0d want 1 %h %0d", imem_req_valid, imem_req_addr, acc_cnt, held, a0);
    end
    imem_req_ready = 1'b1;
    cyc(6);
  endtask

  task automatic test_wrap();
    bit ok = 1'b0;
    b_rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (b_pop_n >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_pops got %0d want 2", b_pop_n); end
    else begin
      checks++;
      if (b_pc[0] !== 16'hFFFE || b_nx[0] !== 16'h0000 || b_in[0] !== 16'h2FFE) begin
        errors++; $display("FAIL wrap_first got pc=%h next=%h instr=%h want FFFE 0000 2FFE", b_pc[0], b_nx[0], b_in[0]);
      end
      checks++;
      if (b_pc[1] !== 16'h0000 || b_nx[1] !== 16'h0002) begin
        errors++; $display("FAIL wrap_second got pc=%h next=%h want 0000 0002", b_pc[1], b_nx[1]);
      end
    end
    b_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_program_halt();
    test_credit();
    test_redirect_flush();
    test_redirect_on_hlt();
    test_reset_mid_wait();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
